mem_stream_engine: RTL and testbench

//  Next-generation DDR read/process/write engine for the Alveo memory tester. Reads run concurrently with writes through a

---
 rtl/mem_stream_engine.sv | 184 ++++++++++++++++++
 tb/tb_mem_stream_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_engine.sv
// Streaming DDR read/transform/write engine: reads flow through a small FIFO to the write master
// (COPY/INVERT), or are compared against a generated lane pattern (CHECK).
module mem_stream_engine #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned SIZE_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] rd_base_addr,
  input  logic [ADDR_W-1:0] wr_base_addr,
  input  logic [SIZE_W-1:0] xfer_bytes,
  input  logic [31:0]       pattern_seed,
  output logic              busy,
  output logic              done,
  output logic [SIZE_W-1:0] err_count,
  output logic [SIZE_W-1:0] beat_count,
  output logic              rd_start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [SIZE_W-1:0] rd_size,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic              rd_done,
  output logic              wr_start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [SIZE_W-1:0] wr_size,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  input  logic              wr_done
);

  localparam int unsigned BEAT_SHIFT = $clog2(DATA_W / 8);
  localparam int unsigned LANES      = DATA_W / 32;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam logic [1:0]  MODE_INVERT = 2'd1;
  localparam logic [1:0]  MODE_CHECK  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FINISH} state_t;

  state_t state, state_next;

  logic [1:0]        mode_q;
  logic [31:0]       seed;
  logic [SIZE_W-1:0] beats;
  logic [SIZE_W-1:0] rd_cnt;
  logic              rd_done_seen;
  logic              wr_done_seen;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic              is_check;
  logic              rd_acc;
  logic              push;
  logic              pop;
  logic              rd_fin;
  logic              wr_fin;
  logic [SIZE_W-1:0] start_beats;
  logic [DATA_W-1:0] expected;

  assign start_beats = xfer_bytes >> BEAT_SHIFT;
  assign is_check    = (mode_q == MODE_CHECK);
  assign expected    = {LANES{seed + 32'(rd_cnt)}};

  // Reads stall when the FIFO is full, independent of a pop in the same cycle.
  assign rd_ready = (state == S_RUN) && (rd_cnt < beats) &&
                    (is_check || (fifo_count < CNT_W'(FIFO_DEPTH)));
  assign wr_valid = (fifo_count != '0);
  assign wr_data  = fifo_mem[rd_ptr];

  assign rd_acc = rd_valid && rd_ready;
  assign push   = rd_acc && !is_check;
  assign pop    = wr_valid && wr_ready;

  // Completion inputs are taken live as well as sticky so done follows the last condition by one cycle.
  assign rd_fin = (rd_cnt == beats) && (rd_done_seen || rd_done);
  assign wr_fin = (beat_count == beats) && (wr_done_seen || wr_done);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LAUNCH;
      S_LAUNCH: state_next = (beats == '0) ? S_FINISH : S_RUN;
      S_RUN:    if (rd_fin && (is_check || wr_fin)) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= (mode_q == MODE_INVERT) ? ~rd_data : rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      err_count    <= '0;
      beat_count   <= '0;
      rd_start     <= 1'b0;
      wr_start     <= 1'b0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      rd_size      <= '0;
      wr_size      <= '0;
      mode_q       <= '0;
      seed         <= '0;
      beats        <= '0;
      rd_cnt       <= '0;
      rd_done_seen <= 1'b0;
      wr_done_seen <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
    end else begin
      rd_start <= 1'b0;
      wr_start <= 1'b0;
      done     <= (state_next == S_FINISH);

      if (busy) begin
        if (rd_done) rd_done_seen <= 1'b1;
        if (wr_done) wr_done_seen <= 1'b1;
      end

      if (rd_acc) begin
        rd_cnt <= rd_cnt + SIZE_W'(1);
        if (is_check) begin
          beat_count <= beat_count + SIZE_W'(1);
          if ((rd_data != expected) && (err_count != '1)) err_count <= err_count + SIZE_W'(1);
        end
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        beat_count <= beat_count + SIZE_W'(1);
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (state == S_FINISH) busy <= 1'b0;

      if ((state == S_IDLE) && start) begin
        busy         <= 1'b1;
        mode_q       <= mode;
        seed         <= pattern_seed;
        rd_addr      <= rd_base_addr;
        wr_addr      <= wr_base_addr;
        rd_size      <= xfer_bytes;
        wr_size      <= xfer_bytes;
        beats        <= start_beats;
        rd_cnt       <= '0;
        beat_count   <= '0;
        err_count    <= '0;
        rd_done_seen <= 1'b0;
        wr_done_seen <= 1'b0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        fifo_count   <= '0;
        rd_start     <= (start_beats != '0);
        wr_start     <= (start_beats != '0) && (mode != MODE_CHECK);
      end
    end
  end

endmodule

// File: tb/tb_mem_stream_engine.sv
// Directed bench for mem_stream_engine with simple read-source and write-sink master models.
module tb_mem_stream_engine;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned SIZE_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] rd_base_addr;
  logic [ADDR_W-1:0] wr_base_addr;
  logic [SIZE_W-1:0] xfer_bytes;
  logic [31:0]       pattern_seed;
  logic              busy;
  logic              done;
  logic [SIZE_W-1:0] err_count;
  logic [SIZE_W-1:0] beat_count;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic [SIZE_W-1:0] rd_size;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_done;
  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr;
  logic [SIZE_W-1:0] wr_size;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_done;

  mem_stream_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .rd_base_addr(rd_base_addr), .wr_base_addr(wr_base_addr),
    .xfer_bytes(xfer_bytes), .pattern_seed(pattern_seed),
    .busy(busy), .done(done), .err_count(err_count), .beat_count(beat_count),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_size(rd_size),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_done(rd_done),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_size(wr_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  int                errors;
  int                checks;
  int                dcount;
  logic [DATA_W-1:0] src_data [64];
  int                src_n, src_lim, src_idx;
  bit                src_active, src_acc;
  int                sink_n;
  bit                sink_active, wr_hold;
  logic [DATA_W-1:0] sink_q [$];
  int                rs_cnt, ws_cnt, wv_cnt;

  // Master models act on the falling edge; the DUT state is stable until the next rising edge.
  always @(negedge clk) begin
    rd_done = 1'b0;
    wr_done = 1'b0;
    wr_ready = !wr_hold;
    if (reset) begin
      src_active  = 1'b0;
      src_acc     = 1'b0;
      sink_active = 1'b0;
      rd_valid    = 1'b0;
    end else begin
      if (rd_start) rs_cnt++;
      if (wr_start) ws_cnt++;
      if (wr_valid) wv_cnt++;
      if (src_acc) src_idx++;
      if (rd_start) begin
        src_active = 1'b1;
        src_idx    = 0;
      end
      if (src_active && src_idx >= src_n) begin
        rd_done    = 1'b1;
        src_active = 1'b0;
      end
      rd_valid = src_active && (src_idx < src_n) && (src_idx < src_lim);
      rd_data  = src_data[src_idx % 64];
      src_acc  = rd_valid && rd_ready;
      if (wr_start) sink_active = 1'b1;
      if (wr_valid && wr_ready) sink_q.push_back(wr_data);
      if (sink_active && sink_q.size() == sink_n) begin
        wr_done     = 1'b1;
        sink_active = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input int bytes, input logic [31:0] sd);
    rs_cnt = 0; ws_cnt = 0; wv_cnt = 0;
    sink_q.delete();
    src_n = bytes / 32;
    sink_n = src_n;
    start = 1'b1; mode = m; xfer_bytes = 32'(bytes); pattern_seed = sd;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    dcount = 0;
    while (dcount == 0 && n < bound) begin
      step(1);
      n++;
      if (done) dcount++;
    end
    repeat (3) begin
      step(1);
      if (done) dcount++;
    end
  endtask

  task automatic fill_pattern(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      for (int l = 0; l < 8; l++)
        src_data[i][l*32 +: 32] = base + 32'(i * 256 + l);
  endtask

  initial begin
    errors = 0; checks = 0; dcount = 0;
    reset = 1'b1; start = 1'b0; mode = 2'd0;
    rd_base_addr = 64'h0000_0012_3456_7000; wr_base_addr = 64'h0000_0034_0000_8000;
    xfer_bytes = '0; pattern_seed = '0;
    wr_hold = 1'b0; src_n = 0; src_lim = 64; src_idx = 0; sink_n = 0;
    src_active = 1'b0; src_acc = 1'b0; sink_active = 1'b0;
    rs_cnt = 0; ws_cnt = 0; wv_cnt = 0;
    rd_valid = 1'b0; rd_data = '0; rd_done = 1'b0; wr_ready = 1'b1; wr_done = 1'b0;
    for (int i = 0; i < 64; i++) src_data[i] = '0;

    step(3);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_err", 256'(err_count), 256'(0));
    chk("rst_beats", 256'(beat_count), 256'(0));
    chk("rst_rd_start", 256'(rd_start), 256'(0));
    chk("rst_wr_valid", 256'(wr_valid), 256'(0));
    chk("rst_rd_ready", 256'(rd_ready), 256'(0));
    chk("rst_rd_addr", 256'(rd_addr), 256'(0));
    reset = 1'b0;
    step(2);

    // COPY 32 beats, with a stray start while busy that must be ignored
    fill_pattern(32, 32'hA500_0000);
    launch(2'd0, 1024, 32'h0);
    chk("copy_rd_start", 256'(rd_start), 256'(1));
    chk("copy_wr_start", 256'(wr_start), 256'(1));
    chk("copy_busy", 256'(busy), 256'(1));
    chk("copy_rd_addr", 256'(rd_addr), 256'(64'h0000_0012_3456_7000));
    chk("copy_wr_addr", 256'(wr_addr), 256'(64'h0000_0034_0000_8000));
    chk("copy_rd_size", 256'(rd_size), 256'(1024));
    chk("copy_wr_size", 256'(wr_size), 256'(1024));
    step(1);
    chk("copy_rd_start_pulse", 256'(rd_start), 256'(0));
    step(4);
    start = 1'b1; mode = 2'd1; xfer_bytes = '0;
    step(1);
    start = 1'b0;
    wait_done(300);
    chk("copy_done_once", 256'(dcount), 256'(1));
    chk("copy_beat_count", 256'(beat_count), 256'(32));
    chk("copy_out_count", 256'(sink_q.size()), 256'(32));
    chk("copy_rd_starts", 256'(rs_cnt), 256'(1));
    chk("copy_busy_end", 256'(busy), 256'(0));
    for (int i = 0; i < 32; i++)
      if (i < sink_q.size()) chk($sformatf("copy_data%0d", i), sink_q[i], src_data[i]);

    // INVERT 4 zero beats
    for (int i = 0; i < 4; i++) src_data[i] = '0;
    launch(2'd1, 128, 32'h0);
    wait_done(100);
    chk("inv_done_once", 256'(dcount), 256'(1));
    chk("inv_err", 256'(err_count), 256'(0));
    chk("inv_beat_count", 256'(beat_count), 256'(4));
    chk("inv_out_count", 256'(sink_q.size()), 256'(4));
    for (int i = 0; i < 4; i++)
      if (i < sink_q.size()) chk($sformatf("inv_data%0d", i), sink_q[i], {DATA_W{1'b1}});

    // Backpressure: sink stalled for 40 cycles, FIFO fills at 16
    fill_pattern(24, 32'h5A00_0000);
    wr_hold = 1'b1;
    launch(2'd0, 768, 32'h0);
    step(40);
    chk("bp_rd_ready", 256'(rd_ready), 256'(0));
    chk("bp_accepted", 256'(src_idx), 256'(16));
    chk("bp_wr_valid", 256'(wr_valid), 256'(1));
    chk("bp_beat_count", 256'(beat_count), 256'(0));
    wr_hold = 1'b0;
    wait_done(200);
    chk("bp_done_once", 256'(dcount), 256'(1));
    chk("bp_out_count", 256'(sink_q.size()), 256'(24));
    for (int i = 0; i < 24; i++)
      if (i < sink_q.size()) chk($sformatf("bp_data%0d", i), sink_q[i], src_data[i]);

    // CHECK seed 0x10, beat 2 lane 3 corrupted
    for (int i = 0; i < 4; i++) src_data[i] = {8{32'h10 + 32'(i)}};
    src_data[2][3*32 +: 32] = 32'h0000_00FF;
    launch(2'd2, 128, 32'h10);
    chk("chk_rd_start", 256'(rd_start), 256'(1));
    chk("chk_wr_start", 256'(wr_start), 256'(0));
    wait_done(100);
    chk("chk_done_once", 256'(dcount), 256'(1));
    chk("chk_err", 256'(err_count), 256'(1));
    chk("chk_beat_count", 256'(beat_count), 256'(4));
    chk("chk_wr_starts", 256'(ws_cnt), 256'(0));
    chk("chk_wr_valid_cycles", 256'(wv_cnt), 256'(0));

    // Zero-length transfer
    launch(2'd0, 0, 32'h0);
    chk("zero_rd_start", 256'(rd_start), 256'(0));
    chk("zero_wr_start", 256'(wr_start), 256'(0));
    chk("zero_busy", 256'(busy), 256'(1));
    chk("zero_done_early", 256'(done), 256'(0));
    step(1);
    chk("zero_done", 256'(done), 256'(1));
    step(1);
    chk("zero_done_pulse", 256'(done), 256'(0));
    chk("zero_busy_end", 256'(busy), 256'(0));
    chk("zero_rd_starts", 256'(rs_cnt), 256'(0));

    // Reset mid-run with 5 beats queued, then a clean transfer
    fill_pattern(12, 32'h3300_0000);
    src_lim = 5;
    wr_hold = 1'b1;
    launch(2'd0, 384, 32'h0);
    step(20);
    chk("mid_accepted", 256'(src_idx), 256'(5));
    chk("mid_wr_valid", 256'(wr_valid), 256'(1));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_busy", 256'(busy), 256'(0));
    chk("mid_wr_valid_rst", 256'(wr_valid), 256'(0));
    chk("mid_rd_ready_rst", 256'(rd_ready), 256'(0));
    chk("mid_beat_count_rst", 256'(beat_count), 256'(0));
    dcount = 0;
    repeat (5) begin
      step(1);
      if (done) dcount++;
    end
    chk("mid_no_done", 256'(dcount), 256'(0));
    src_lim = 64;
    wr_hold = 1'b0;
    fill_pattern(3, 32'h7700_0000);
    launch(2'd0, 96, 32'h0);
    wait_done(100);
    chk("post_done_once", 256'(dcount), 256'(1));
    chk("post_beat_count", 256'(beat_count), 256'(3));
    chk("post_out_count", 256'(sink_q.size()), 256'(3));
    for (int i = 0; i < 3; i++)
      if (i < sink_q.size()) chk($sformatf("post_data%0d", i), sink_q[i], src_data[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
